spi_reg_cmd_decoder: RTL and testbench
======================================

# spi_reg_cmd_decoder

Parametrised SPI command decoder between the SPI slave byte receiver and the register file. Extends the single-command read-burst decoder with three additions: a write-burst command, an address-set command, and a configurable register count with optional address wrap. It converts a stream of command bytes (dc_i=0) and data bytes (dc_i=1) into register read-pointer and write-strobe traffic.

## Interface
Parameters:
- REG_NUM, 7: number of addressable registers (≥2).
- ADDR_W, $clog2(REG_NUM): register address width.
- RD_CMD, 8'h3B: read-burst command code.
- WR_CMD, 8'h3C: write-burst command code.
- ADDR_CMD, 8'h2A: address-set command code.
- WRAP, 0: 1 = burst pointer wraps to 0 after REG_NUM-1; 0 = burst terminates.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- dc_i  in  1  0 = command byte, 1 = data byte; sampled only when spi_byte_vld_i=1.
- spi_byte_vld_i  in  1  one-cycle strobe, byte valid.
- spi_byte_data_i  in  8  received byte.
- reg_rd_en_o  out  1  high while a read burst is active.
- reg_rd_addr_o  out  ADDR_W  current read pointer.
- reg_wr_en_o  out  1  one-cycle write strobe.
- reg_wr_addr_o  out  ADDR_W  write address, valid with reg_wr_en_o.
- reg_wr_data_o  out  8  write data, valid with reg_wr_en_o.
- cmd_err_o  out  1  one-cycle pulse on unknown command or out-of-range address.

## Operation
- State register: IDLE, ADDR, READ, WRITE. Pointer register ptr[ADDR_W-1:0]. All logic updates only on cycles with spi_byte_vld_i=1, except reg_wr_en_o and cmd_err_o, which clear on the next cycle.
- Command byte in any state (aborts any burst in progress; ptr unchanged):
  - RD_CMD → READ.
  - WR_CMD → WRITE.
  - ADDR_CMD → ADDR.
  - Any other code → IDLE, cmd_err_o pulse.
- Data byte handling by state:
  - IDLE: ignored, no error.
  - ADDR: if byte < REG_NUM, ptr ← byte[ADDR_W-1:0]; otherwise ptr unchanged and cmd_err_o pulses. Either way → IDLE.
  - READ: advance ptr (rule below).
  - WRITE: reg_wr_en_o=1, reg_wr_addr_o=ptr (pre-advance value), reg_wr_data_o=byte; then advance ptr.
- Advance rule, applied in READ and WRITE:
  - ptr < REG_NUM-1: ptr+1.
  - ptr == REG_NUM-1 and WRAP=1: ptr ← 0, state unchanged.
  - ptr == REG_NUM-1 and WRAP=0: ptr ← 0, → IDLE. The final write strobe is still issued.
- reg_rd_en_o = (state==READ); reg_rd_addr_o = ptr. Both are registered.
- Arithmetic: ptr comparisons are unsigned at ADDR_W bits, and ptr never holds a value ≥ REG_NUM. The data-byte comparison against REG_NUM uses the full 8 bits.

## Timing
- Reset values: state IDLE, ptr 0, every output 0.
- Latency: all outputs are registered and reflect a byte one cycle after its spi_byte_vld_i cycle.
- reg_wr_en_o and cmd_err_o are exactly one cycle wide per triggering byte. Back-to-back vld cycles give back-to-back strobes with no gap.
- With spi_byte_vld_i=0, dc_i and data are don't-care and state is held.
- Reset asserted mid-burst: immediate return to reset values. Any pending strobe is dropped.
- The first data byte after RD_CMD sees reg_rd_addr_o equal to the starting ptr: the register file presents the data at ptr, then ptr advances.

## Test plan
- Reset, then RD_CMD followed by 7 data bytes (REG_NUM=7, WRAP=0) → reg_rd_en_o=1 with reg_rd_addr_o stepping 0..6; after the 7th byte reg_rd_en_o=0 and addr=0.
- ADDR_CMD, data 0x04, WR_CMD, data 0xAA, 0xBB, 0xCC (WRAP=1) → strobes at (4,AA), (5,BB), (6,CC); ptr ends at 0 and state stays WRITE.
- ADDR_CMD with data 0x07 (REG_NUM=7) → cmd_err_o pulses once and ptr is unchanged. Command 0x55 → cmd_err_o pulses and state returns to IDLE.
- Read burst aborted after 2 bytes by WR_CMD, then data 0x11 → reg_rd_en_o drops one cycle after WR_CMD; write strobe at (2,11).
- Data bytes in IDLE, and vld=0 with toggling dc_i/data → no output change.
- Assert rst_n_i between write bytes → no further strobe and all outputs 0 immediately. Repeat with REG_NUM=16, ADDR_W=4 for wrap at 15.

Source files
------------

// File: rtl/spi_reg_cmd_decoder.sv
// SPI command decoder: turns command/data byte stream into register read-pointer
// and write-strobe traffic, with read-burst, write-burst and address-set commands.
module spi_reg_cmd_decoder #(
   parameter int unsigned REG_NUM  = 7,
   parameter int unsigned ADDR_W   = $clog2(REG_NUM),
   parameter logic [7:0]  RD_CMD   = 8'h3B,
   parameter logic [7:0]  WR_CMD   = 8'h3C,
   parameter logic [7:0]  ADDR_CMD = 8'h2A,
   parameter bit          WRAP     = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              dc_i,
   input  logic              spi_byte_vld_i,
   input  logic [7:0]        spi_byte_data_i,
   output logic              reg_rd_en_o,
   output logic [ADDR_W-1:0] reg_rd_addr_o,
   output logic              reg_wr_en_o,
   output logic [ADDR_W-1:0] reg_wr_addr_o,
   output logic [7:0]        reg_wr_data_o,
   output logic              cmd_err_o
);

   typedef enum logic [1:0] {StIdle, StAddr, StRead, StWrite} state_e;

   localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(REG_NUM - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              err_q, err_d;

   logic              at_last;
   logic [ADDR_W-1:0] ptr_adv;
   state_e            state_adv;

   // Burst advance: past the last register either wrap in place or end the burst.
   assign at_last   = (ptr_q == LastPtr);
   assign ptr_adv   = at_last ? '0 : ptr_q + ADDR_W'(1);
   assign state_adv = (at_last && !WRAP) ? StIdle : state_q;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = 1'b0;
      if (spi_byte_vld_i) begin
         if (!dc_i) begin
            case (spi_byte_data_i)
               RD_CMD:   state_d = StRead;
               WR_CMD:   state_d = StWrite;
               ADDR_CMD: state_d = StAddr;
               default: begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end
            endcase
         end else begin
            case (state_q)
               StAddr: begin
                  // Range check on the full byte so high bits cannot alias into range.
                  if ({24'd0, spi_byte_data_i} < REG_NUM) begin
                     ptr_d = spi_byte_data_i[ADDR_W-1:0];
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = StIdle;
               end
               StRead: begin
                  ptr_d   = ptr_adv;
                  state_d = state_adv;
               end
               StWrite: begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = spi_byte_data_i;
                  ptr_d     = ptr_adv;
                  state_d   = state_adv;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   assign reg_rd_en_o   = (state_q == StRead);
   assign reg_rd_addr_o = ptr_q;
   assign reg_wr_en_o   = wr_en_q;
   assign reg_wr_addr_o = wr_addr_q;
   assign reg_wr_data_o = wr_data_q;
   assign cmd_err_o     = err_q;

endmodule

// File: tb/tb_spi_reg_cmd_decoder.sv
// Scoreboard bench for spi_reg_cmd_decoder: three configurations (7/no-wrap, 7/wrap, 16/wrap)
// share one byte bus; a negedge monitor pops expected strobes/errors as they appear.
module tb_spi_reg_cmd_decoder;

   localparam logic [7:0] RD = 8'h3B, WR = 8'h3C, AD = 8'h2A;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dc = 1'b0;
   logic [7:0] data = 8'h00;
   logic [2:0] vld = 3'b000;
   logic [2:0] rd_en, wr_en, err;
   logic [2:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
   logic [3:0] rd_addr2, wr_addr2;
   logic [7:0] wr_data0, wr_data1, wr_data2;

   typedef struct {int dut; bit is_err; logic [3:0] addr; logic [7:0] data;} ev_t;
   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   always #5 clk = ~clk;

   spi_reg_cmd_decoder #(.REG_NUM(7), .WRAP(1'b0)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .dc_i(dc), .spi_byte_vld_i(vld[0]), .spi_byte_data_i(data),
      .reg_rd_en_o(rd_en[0]), .reg_rd_addr_o(rd_addr0), .reg_wr_en_o(wr_en[0]),
      .reg_wr_addr_o(wr_addr0), .reg_wr_data_o(wr_data0), .cmd_err_o(err[0]));

   spi_reg_cmd_decoder #(.REG_NUM(7), .WRAP(1'b1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .dc_i(dc), .spi_byte_vld_i(vld[1]), .spi_byte_data_i(data),
      .reg_rd_en_o(rd_en[1]), .reg_rd_addr_o(rd_addr1), .reg_wr_en_o(wr_en[1]),
      .reg_wr_addr_o(wr_addr1), .reg_wr_data_o(wr_data1), .cmd_err_o(err[1]));

   spi_reg_cmd_decoder #(.REG_NUM(16), .WRAP(1'b1)) dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .dc_i(dc), .spi_byte_vld_i(vld[2]), .spi_byte_data_i(data),
      .reg_rd_en_o(rd_en[2]), .reg_rd_addr_o(rd_addr2), .reg_wr_en_o(wr_en[2]),
      .reg_wr_addr_o(wr_addr2), .reg_wr_data_o(wr_data2), .cmd_err_o(err[2]));

   function automatic logic [3:0] raddr(input int d);
      case (d)
         0:       return {1'b0, rd_addr0};
         1:       return {1'b0, rd_addr1};
         default: return rd_addr2;
      endcase
   endfunction

   function automatic logic [3:0] waddr(input int d);
      case (d)
         0:       return {1'b0, wr_addr0};
         1:       return {1'b0, wr_addr1};
         default: return wr_addr2;
      endcase
   endfunction

   function automatic logic [7:0] wdata(input int d);
      case (d)
         0:       return wr_data0;
         1:       return wr_data1;
         default: return wr_data2;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic check_rd(input string name, input int d, input bit en, input int addr);
      check({name, "_rd_en"}, int'(rd_en[d]), int'(en));
      check({name, "_rd_addr"}, int'(raddr(d)), addr);
   endtask

   task automatic exp_wr(input int d, input logic [3:0] a, input logic [7:0] b);
      exp_q.push_back('{dut: d, is_err: 1'b0, addr: a, data: b});
   endtask

   task automatic exp_err(input int d);
      exp_q.push_back('{dut: d, is_err: 1'b1, addr: 4'h0, data: 8'h00});
   endtask

   // Drives one byte for one cycle; consecutive calls keep vld high back-to-back.
   task automatic send(input int d, input bit c, input logic [7:0] b);
      vld    = 3'b000;
      vld[d] = 1'b1;
      dc     = c;
      data   = b;
      @(posedge clk);
      #1;
      vld = 3'b000;
   endtask

   task automatic mon_pop(input int d, input bit is_err, input logic [3:0] a, input logic [7:0] b);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event dut%0d err=%0b addr=%0h data=%0h, required none",
                  d, is_err, a, b);
      end else begin
         e = exp_q.pop_front();
         if (e.dut != d || e.is_err != is_err || (!is_err && (e.addr != a || e.data != b))) begin
            fails++;
            $display("FAIL event: got dut%0d err=%0b addr=%0h data=%0h, required dut%0d err=%0b addr=%0h data=%0h",
                     d, is_err, a, b, e.dut, e.is_err, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (wr_en[i]) mon_pop(i, 1'b0, waddr(i), wdata(i));
         if (err[i])   mon_pop(i, 1'b1, 4'h0, 8'h00);
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_rd("reset", i, 1'b0, 0);
         check("reset_wr_en", int'(wr_en[i]), 0);
         check("reset_err", int'(err[i]), 0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full read burst, no wrap: pointer 0..6 then burst ends at 0.
      send(0, 1'b0, RD);
      check_rd("rd_start", 0, 1'b1, 0);
      for (int i = 0; i < 7; i++) begin
         send(0, 1'b1, 8'h00);
         if (i < 6) check_rd("rd_step", 0, 1'b1, i + 1);
         else       check_rd("rd_end", 0, 1'b0, 0);
      end

      // Address set and out-of-range rejects (0x09 must not alias to 1).
      send(0, 1'b0, AD); send(0, 1'b1, 8'h03);
      check_rd("addr_set", 0, 1'b0, 3);
      send(0, 1'b0, AD); exp_err(0); send(0, 1'b1, 8'h07);
      check_rd("addr_07", 0, 1'b0, 3);
      send(0, 1'b0, AD); exp_err(0); send(0, 1'b1, 8'h09);
      check_rd("addr_09", 0, 1'b0, 3);
      send(0, 1'b0, RD);
      check_rd("pre_bad_cmd", 0, 1'b1, 3);
      exp_err(0); send(0, 1'b0, 8'h55);
      check_rd("bad_cmd", 0, 1'b0, 3);

      // Read aborted by write command.
      send(0, 1'b0, AD); send(0, 1'b1, 8'h00);
      send(0, 1'b0, RD); send(0, 1'b1, 8'hF0); send(0, 1'b1, 8'hF1);
      check_rd("abort_pre", 0, 1'b1, 2);
      send(0, 1'b0, WR);
      check_rd("abort", 0, 1'b0, 2);
      exp_wr(0, 4'd2, 8'h11); send(0, 1'b1, 8'h11);
      check_rd("abort_wr", 0, 1'b0, 3);

      // Idle data bytes and vld=0 activity are ignored.
      send(0, 1'b0, AD); send(0, 1'b1, 8'h01);
      send(0, 1'b1, 8'h3B); send(0, 1'b1, 8'h77);
      check_rd("idle_data", 0, 1'b0, 1);
      send(0, 1'b0, WR);
      for (int i = 0; i < 6; i++) begin
         dc   = i[0];
         data = (i[1]) ? RD : 8'h5A;
         @(posedge clk);
         #1;
      end
      check_rd("vld_low", 0, 1'b0, 1);

      // Back-to-back writes to the end, no wrap: final strobe then idle.
      send(0, 1'b0, AD); send(0, 1'b1, 8'h05); send(0, 1'b0, WR);
      exp_wr(0, 4'd5, 8'hA1); send(0, 1'b1, 8'hA1);
      exp_wr(0, 4'd6, 8'hA2); send(0, 1'b1, 8'hA2);
      check_rd("wr_end", 0, 1'b0, 0);
      send(0, 1'b1, 8'hA3);

      // Write burst with wrap at 6, stays in WRITE.
      send(1, 1'b0, AD); send(1, 1'b1, 8'h04); send(1, 1'b0, WR);
      exp_wr(1, 4'd4, 8'hAA); send(1, 1'b1, 8'hAA);
      exp_wr(1, 4'd5, 8'hBB); send(1, 1'b1, 8'hBB);
      exp_wr(1, 4'd6, 8'hCC); send(1, 1'b1, 8'hCC);
      check_rd("wrap_ptr", 1, 1'b0, 0);
      exp_wr(1, 4'd0, 8'hDD); send(1, 1'b1, 8'hDD);

      // Reset while a strobe is high: strobe dropped, outputs cleared immediately.
      send(1, 1'b0, AD); send(1, 1'b1, 8'h03); send(1, 1'b0, WR);
      send(1, 1'b1, 8'h10);
      rst_n = 1'b0;
      #1;
      check("rst_wr_en", int'(wr_en[1]), 0);
      check_rd("rst_mid", 1, 1'b0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(1, 1'b1, 8'h30);

      // 16 registers: wrap at 15, range check at 16.
      send(2, 1'b0, AD); send(2, 1'b1, 8'h0E); send(2, 1'b0, WR);
      exp_wr(2, 4'd14, 8'h01); send(2, 1'b1, 8'h01);
      exp_wr(2, 4'd15, 8'h02); send(2, 1'b1, 8'h02);
      exp_wr(2, 4'd0, 8'h03);  send(2, 1'b1, 8'h03);
      send(2, 1'b0, AD); exp_err(2); send(2, 1'b1, 8'h10);
      check_rd("r16_bad", 2, 1'b0, 1);
      send(2, 1'b0, AD); send(2, 1'b1, 8'h0F); send(2, 1'b0, RD);
      check_rd("r16_rd15", 2, 1'b1, 15);
      send(2, 1'b1, 8'h00);
      check_rd("r16_wrap", 2, 1'b1, 0);

      repeat (3) @(posedge clk);
      #1;
      check("leftover_expected", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
